// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and read-responder types.
package axi_pkg;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'd0,
    AXI_BURST_INCR  = 2'd1,
    AXI_BURST_WRAP  = 2'd2
  } axi_burst_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'd1;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;
  localparam logic [1:0] AXI_RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } rd_state_t;

  // Burst shape latched at the AR handshake.
  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } ar_ctl_t;

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts.
module axi_burst_addr
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr_c
);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] container;
  logic [ADDR_WIDTH-1:0] wrap_base;

  // Step by one beat; WRAP folds back to the aligned container base.
  always_comb begin
    step        = ADDR_WIDTH'(1) << size;
    incr        = addr + step;
    container   = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
    wrap_base   = addr & ~(container - ADDR_WIDTH'(1));
    next_addr_c = incr;
    case (burst)
      AXI_BURST_FIXED: next_addr_c = addr;
      AXI_BURST_WRAP:  next_addr_c = (incr == wrap_base + container) ? wrap_base : incr;
      default:         next_addr_c = incr;
    endcase
  end

endmodule

// File: rtl/axi_rd_responder.sv
// AXI4 read subordinate: single outstanding burst served from a preloadable memory.
module axi_rd_responder
  import axi_pkg::*;
#(
  parameter int unsigned     ID_WIDTH     = 13,
  parameter int unsigned     ADDR_WIDTH   = 64,
  parameter int unsigned     DATA_WIDTH   = 64,
  parameter int unsigned     MEM_WORDS    = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int unsigned     READ_LATENCY = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ID_WIDTH-1:0]          s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
  input  logic [7:0]                   s_axi_arlen,
  input  logic [2:0]                   s_axi_arsize,
  input  logic [1:0]                   s_axi_arburst,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [ID_WIDTH-1:0]          s_axi_rid,
  output logic [DATA_WIDTH-1:0]        s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rlast,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  input  logic                         pre_we,
  input  logic [$clog2(MEM_WORDS)-1:0] pre_idx,
  input  logic [DATA_WIDTH-1:0]        pre_data
);

  localparam int unsigned IDX_W      = $clog2(MEM_WORDS);
  localparam int unsigned WORD_SHIFT = $clog2(DATA_WIDTH / 8);
  localparam logic [7:0]  LAT_INIT   = 8'(READ_LATENCY - 1);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  rd_state_t             state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [7:0]            beat_q, beat_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  ar_ctl_t               ctl_q, ctl_d;
  logic                  slverr_q, slverr_d;

  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [ADDR_WIDTH-1:0] next_addr_c;
  logic [ADDR_WIDTH-1:0] word_off;
  logic                  beat_decerr;
  logic                  load_beat;
  logic [DATA_WIDTH-1:0] mem_word;

  axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_burst_addr (
    .addr        (addr_q),
    .size        (ctl_q.size),
    .len         (ctl_q.len),
    .burst       (ctl_q.burst),
    .next_addr_c (next_addr_c)
  );

  // Decode the pending beat address into a word index and decode error.
  always_comb begin
    word_off    = (addr_q - BASE_ADDR) >> WORD_SHIFT;
    beat_decerr = (addr_q < BASE_ADDR) || (word_off >= ADDR_WIDTH'(MEM_WORDS));
    mem_word    = mem[word_off[IDX_W-1:0]];
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    beat_d    = beat_q;
    id_d      = id_q;
    addr_d    = addr_q;
    ctl_d     = ctl_q;
    slverr_d  = slverr_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    load_beat = 1'b0;

    case (state_q)
      IDLE: begin
        if (s_axi_arvalid && arready_q) begin
          id_d      = s_axi_arid;
          addr_d    = s_axi_araddr;
          ctl_d     = '{len: s_axi_arlen, size: s_axi_arsize, burst: s_axi_arburst};
          slverr_d  = (32'(s_axi_arsize) > WORD_SHIFT) ||
                      (s_axi_arburst == 2'd3) ||
                      ((s_axi_arburst == AXI_BURST_WRAP) &&
                       !(s_axi_arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));
          cnt_d     = LAT_INIT;
          beat_d    = 8'd0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 8'd0) begin
          load_beat = 1'b1;
          rvalid_d  = 1'b1;
          state_d   = SEND;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      SEND: begin
        if (s_axi_rready) begin
          if (rlast_q) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            state_d  = IDLE;
          end else begin
            load_beat = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_beat) begin
      rid_d   = id_q;
      rlast_d = (beat_q == ctl_q.len);
      if (beat_decerr) begin
        rresp_d = AXI_RESP_DECERR;
        rdata_d = '0;
      end else if (slverr_q) begin
        rresp_d = AXI_RESP_SLVERR;
        rdata_d = '0;
      end else begin
        rresp_d = AXI_RESP_OKAY;
        rdata_d = mem_word;
      end
      addr_d = next_addr_c;
      beat_d = beat_q + 8'd1;
    end

    arready_d = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      beat_q    <= '0;
      id_q      <= '0;
      addr_q    <= '0;
      ctl_q     <= '0;
      slverr_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= '0;
      rid_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      beat_q    <= beat_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      ctl_q     <= ctl_d;
      slverr_q  <= slverr_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
    end
  end

  // Backdoor preload; reads in the same cycle see the old word.
  always_ff @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rdata   = rdata_q;

endmodule
